avalon_sc_pkt_fifo: RTL and testbench
=====================================

Name: avalon_sc_pkt_fifo

Overview:
- Parametrised single-clock Avalon-ST FIFO; next generation of the 64-bit clock-crossing FIFO.
- Adds configurable width and depth, packet sideband (SOP/EOP/empty), fill level, and almost-full/almost-empty flags.
- Sits between the 10GBASE-R MAC datapath and the JTAG debug capture logic where no clock crossing is needed.

Parameters:
- DATA_W, 64, payload width in bits; must be a multiple of 8.
- DEPTH, 16, number of entries; power of 2, ≥4.
- EMPTY_W, $clog2(DATA_W/8), width of the empty field (derived; do not override).
- AF_TH, DEPTH-2, almost_full asserts when fill_level ≥ AF_TH.
- AE_TH, 2, almost_empty asserts when fill_level ≤ AE_TH.

Ports:
- clk_clk  in  1  single clock; all logic on rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  sink payload.
- in_valid  in  1  sink valid.
- in_ready  out  1  sink ready.
- in_startofpacket  in  1  sink SOP.
- in_endofpacket  in  1  sink EOP.
- in_empty  in  EMPTY_W  unused bytes on the EOP beat.
- out_data  out  DATA_W  source payload.
- out_valid  out  1  source valid.
- out_ready  in  1  source ready.
- out_startofpacket  out  1  source SOP.
- out_endofpacket  out  1  source EOP.
- out_empty  out  EMPTY_W  source empty.
- fill_level  out  $clog2(DEPTH)+1  stored entries.
- almost_full  out  1  fill_level ≥ AF_TH.
- almost_empty  out  1  fill_level ≤ AE_TH.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Storage: each entry holds {data, sop, eop, empty}.
- Pointers: write and read pointers are $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty. Pointers wrap naturally modulo 2*DEPTH.
- Write handshake: write occurs when in_valid && in_ready.
  - in_ready = !full, registered.
  - in_ready does not depend on out_ready (no combinational path).
- Read handshake: read occurs when out_valid && out_ready.
- Latency: show-ahead. Data written in cycle N is visible on out_* with out_valid=1 in cycle N+1 (write-to-valid latency is 1 cycle).
- out_valid = !empty.
- out_* hold stable while out_valid && !out_ready.
- Full with simultaneous read: in_ready is 0, so no write occurs. The read frees a slot and in_ready rises the next cycle.
- Empty with simultaneous write: no read occurs. out_valid rises the next cycle.
- Non-boundary simultaneous read and write: fill_level is unchanged.
- fill_level updates each cycle by +1, -1 or 0. It saturates by construction: never exceeds DEPTH, never underflows.
- almost_full and almost_empty are registered and derived from the next fill_level, so they are coincident with fill_level.
- Packet sideband:
  - Stored and returned unmodified; no framing checks.
  - in_empty is ignored unless in_endofpacket=1. The FIFO still stores it.
- Reset values:
  - in_ready=0 during reset, 1 the cycle after reset deasserts.
  - out_valid=0, fill_level=0, almost_full=0, almost_empty=1.
  - out_data, out_startofpacket, out_endofpacket and out_empty are don't-care but driven; implemented as 0.
- Reset mid-operation: all contents are discarded, pointers return to 0, and any in-flight beat is lost. Memory contents need not be cleared.

Optional Feature:
- Macro: AVALON_SC_PKT_FIFO_SAF_EN, store-and-forward mode.
- With the macro defined:
  - A packet counter tracks complete packets stored. It increments on a written EOP beat and decrements on a read EOP beat.
  - out_valid = !empty && (pkt_cnt != 0).
  - A packet longer than DEPTH would deadlock. It is therefore accepted by forcing out_valid=1 when full (cut-through fallback).
- Without the macro: cut-through as described above; no packet counter logic.

Decomposition:
- Shared package avalon_st_pkg:
  - typedef for the Avalon-ST beat struct {sop, eop, empty, data}, parametrised via a DATA_W-sized localparam.
  - function clog2_safe.
  - constant AVST_BYTE_W=8.
- One natural sub-module: sc_fifo_ram (simple dual-port, one write port, asynchronous-read array). Inferred as MLAB/distributed RAM.

Test Plan:
- Reset, then 1 beat written (data 0x0123456789ABCDEF, sop=1, eop=1, empty=3) -> out_valid=1 the next cycle with identical fields; fill_level 1→0 after read.
- Write 16 beats with out_ready=0 (DEPTH=16) -> in_ready=0 after the 16th; fill_level=16, almost_full=1 from fill_level=14.
- Full, then in_valid=1 and out_ready=1 together -> no write that cycle; fill_level=15; in_ready=1 the next cycle.
- Random in_valid/out_ready at 50% over 10k beats with incrementing data -> output sequence exactly matches input; no loss or duplication; fill_level matches a scoreboard every cycle.
- Assert reset_reset at fill_level=7 -> the next cycle shows fill_level=0, out_valid=0, almost_empty=1; the following write is read back correctly.
- SAF_EN: write a 5-beat packet with a 2-cycle gap before EOP -> out_valid stays 0 until the cycle after the EOP write. With an 18-beat packet, out_valid is forced to 1 when full.

Source files
------------

// File: rtl/avalon_st_pkg.sv
// Shared Avalon-ST definitions: byte width, beat payload struct, width helper.
// No ports (package).
package avalon_st_pkg;

   localparam int unsigned AVST_BYTE_W = 8;

   // Width helper that never returns 0, so derived fields stay at least 1 bit.
   function automatic int unsigned clog2_safe(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned AVST_DATA_W  = 64;
   localparam int unsigned AVST_EMPTY_W = clog2_safe(AVST_DATA_W / AVST_BYTE_W);

   // One Avalon-ST beat at the default payload width.
   typedef struct packed {
      logic                    sop;
      logic                    eop;
      logic [AVST_EMPTY_W-1:0] empty;
      logic [AVST_DATA_W-1:0]  data;
   } avst_beat_t;

endpackage

// File: rtl/sc_fifo_ram.sv
// Simple dual-port storage array: one synchronous write port and one
// asynchronous read port (maps to distributed/MLAB RAM).
// Ports: clk, we/waddr/wdata (write), raddr/rd_data_c (combinational read).
module sc_fifo_ram #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rd_data_c
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rd_data_c = mem[raddr];

endmodule

// File: rtl/avalon_sc_pkt_fifo.sv
// Single-clock show-ahead Avalon-ST FIFO with packet sideband, fill level and
// almost-full/almost-empty flags. All outputs are registered.
// Optional: define AVALON_SC_PKT_FIFO_SAF_EN for store-and-forward mode (output
// held off until a complete packet is stored, with a cut-through fallback
// when full so oversize packets cannot deadlock).
// Ports:
//   clk_clk, reset_reset (sync, active-high)
//   in_*  : Avalon-ST sink (data, valid, ready, sop, eop, empty)
//   out_* : Avalon-ST source (data, valid, ready, sop, eop, empty)
//   fill_level, almost_full, almost_empty : occupancy status
module avalon_sc_pkt_fifo
   import avalon_st_pkg::*;
#(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned EMPTY_W = clog2_safe(DATA_W / AVST_BYTE_W),
   parameter int unsigned AF_TH   = DEPTH - 2,
   parameter int unsigned AE_TH   = 2
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_startofpacket,
   input  logic                   in_endofpacket,
   input  logic [EMPTY_W-1:0]     in_empty,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_startofpacket,
   output logic                   out_endofpacket,
   output logic [EMPTY_W-1:0]     out_empty,
   output logic [$clog2(DEPTH):0] fill_level,
   output logic                   almost_full,
   output logic                   almost_empty
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned ENT_W  = DATA_W + EMPTY_W + 2;

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt, fill_nxt;
   logic             wr_en, rd_en;
   logic             in_ready_nxt, out_valid_nxt, af_nxt, ae_nxt;
   logic [ENT_W-1:0] wr_ent, ram_rdata, head_nxt;
   logic             saf_ok;

   assign wr_ent = {in_startofpacket, in_endofpacket, in_empty, in_data};

   sc_fifo_ram #(
      .WIDTH  (ENT_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk_clk),
      .we        (wr_en),
      .waddr     (wr_ptr[ADDR_W-1:0]),
      .wdata     (wr_ent),
      .raddr     (rd_ptr_nxt[ADDR_W-1:0]),
      .rd_data_c (ram_rdata)
   );

`ifdef AVALON_SC_PKT_FIFO_SAF_EN
   logic [PTR_W-1:0] pkt_cnt, pkt_cnt_nxt;

   // Complete packets currently stored.
   always_comb begin
      pkt_cnt_nxt = pkt_cnt + PTR_W'(wr_en && in_endofpacket)
                            - PTR_W'(rd_en && out_endofpacket);
      saf_ok      = (pkt_cnt_nxt != '0) || (fill_nxt == PTR_W'(DEPTH));
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) pkt_cnt <= '0;
      else             pkt_cnt <= pkt_cnt_nxt;
   end
`else
   assign saf_ok = 1'b1;
`endif

   // Next-state for pointers, occupancy and flags.
   always_comb begin
      wr_en         = in_valid && in_ready;
      rd_en         = out_valid && out_ready;
      wr_ptr_nxt    = wr_ptr + PTR_W'(wr_en);
      rd_ptr_nxt    = rd_ptr + PTR_W'(rd_en);
      // Pointer difference is bounded to 0..DEPTH, so no explicit saturation.
      fill_nxt      = wr_ptr_nxt - rd_ptr_nxt;
      in_ready_nxt  = (fill_nxt != PTR_W'(DEPTH));
      out_valid_nxt = (fill_nxt != '0) && saf_ok;
      af_nxt        = (fill_nxt >= PTR_W'(AF_TH));
      ae_nxt        = (fill_nxt <= PTR_W'(AE_TH));
      // A write into the slot that becomes head only happens when the FIFO
      // was empty; forward it so the registered head is current next cycle.
      head_nxt      = (wr_en && (wr_ptr[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]))
                      ? wr_ent : ram_rdata;
   end

   // State and registered outputs.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         fill_level        <= '0;
         in_ready          <= 1'b0;
         out_valid         <= 1'b0;
         almost_full       <= 1'b0;
         almost_empty      <= 1'b1;
         out_data          <= '0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_empty         <= '0;
      end else begin
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         fill_level   <= fill_nxt;
         in_ready     <= in_ready_nxt;
         out_valid    <= out_valid_nxt;
         almost_full  <= af_nxt;
         almost_empty <= ae_nxt;
         {out_startofpacket, out_endofpacket, out_empty, out_data} <= head_nxt;
      end
   end

endmodule

// File: tb/tb_avalon_sc_pkt_fifo.sv
// Self-checking bench for avalon_sc_pkt_fifo (default parameters).
module tb_avalon_sc_pkt_fifo;
   import avalon_st_pkg::*;

   localparam int DEPTH = 16;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [63:0]             in_data = '0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic                    in_sop = 1'b0;
   logic                    in_eop = 1'b0;
   logic [AVST_EMPTY_W-1:0] in_empty = '0;
   logic [63:0]             out_data;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic                    out_sop;
   logic                    out_eop;
   logic [AVST_EMPTY_W-1:0] out_empty;
   logic [4:0]              fill_level;
   logic                    almost_full;
   logic                    almost_empty;

   int checks = 0;
   int errors = 0;

   // Reference model state
   avst_beat_t q[$];
   int   m_fill = 0;
   int   m_pkt  = 0;
   logic m_in_ready  = 1'b0;
   logic m_out_valid = 1'b0;
   logic m_af = 1'b0;
   logic m_ae = 1'b1;

   avalon_sc_pkt_fifo dut (
      .clk_clk           (clk),
      .reset_reset       (reset),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_startofpacket  (in_sop),
      .in_endofpacket    (in_eop),
      .in_empty          (in_empty),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop),
      .out_empty         (out_empty),
      .fill_level        (fill_level),
      .almost_full       (almost_full),
      .almost_empty      (almost_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: pushes each accepted beat, pops each consumed beat.
   initial forever begin
      @(posedge clk);
      if (reset) begin
         q.delete();
         m_pkt = 0;
         m_in_ready  = 1'b0;
         m_out_valid = 1'b0;
      end else begin
         automatic logic w = in_valid && m_in_ready;
         automatic logic r = m_out_valid && out_ready;
         avst_beat_t b;
         if (r) begin
            if (q[0].eop) m_pkt--;
            void'(q.pop_front());
         end
         if (w) begin
            b.sop = in_sop; b.eop = in_eop; b.empty = in_empty; b.data = in_data;
            q.push_back(b);
            if (in_eop) m_pkt++;
         end
         m_in_ready  = (q.size() != DEPTH);
`ifdef AVALON_SC_PKT_FIFO_SAF_EN
         m_out_valid = (q.size() != 0) && ((m_pkt != 0) || (q.size() == DEPTH));
`else
         m_out_valid = (q.size() != 0);
`endif
      end
      m_fill = q.size();
      m_af   = (m_fill >= DEPTH - 2);
      m_ae   = (m_fill <= 2);
   end

   // Monitor: compares DUT status and head beat against the model each cycle.
   initial forever begin
      @(negedge clk);
      chk("in_ready",     64'(in_ready),     64'(m_in_ready));
      chk("out_valid",    64'(out_valid),    64'(m_out_valid));
      chk("fill_level",   64'(fill_level),   64'(m_fill));
      chk("almost_full",  64'(almost_full),  64'(m_af));
      chk("almost_empty", 64'(almost_empty), 64'(m_ae));
      if (m_out_valid && q.size() != 0) begin
         chk("out_data",  out_data,         q[0].data);
         chk("out_sop",   64'(out_sop),     64'(q[0].sop));
         chk("out_eop",   64'(out_eop),     64'(q[0].eop));
         chk("out_empty", 64'(out_empty),   64'(q[0].empty));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic s, input logic e,
                        input logic [AVST_EMPTY_W-1:0] em);
      in_valid = v; in_data = d; in_sop = s; in_eop = e; in_empty = em;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 50 && !m_in_ready; i++) cyc();
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && fill_level != 0; i++) cyc();
      chk("drain_empty", 64'(fill_level), 64'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      int cnt;
      // Reset state
      repeat (3) cyc();
      chk("rst_in_ready",     64'(in_ready),     64'd0);
      chk("rst_out_valid",    64'(out_valid),    64'd0);
      chk("rst_fill",         64'(fill_level),   64'd0);
      chk("rst_almost_full",  64'(almost_full),  64'd0);
      chk("rst_almost_empty", 64'(almost_empty), 64'd1);
      chk("rst_out_data",     out_data,          64'd0);
      reset = 1'b0;
      cyc();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Single beat, show-ahead latency of one cycle
      drive(1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b1, 3'd3);
      cyc();
      in_valid = 1'b0;
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_data",  out_data, 64'h0123456789ABCDEF);
      chk("t1_sop",   64'(out_sop), 64'd1);
      chk("t1_eop",   64'(out_eop), 64'd1);
      chk("t1_empty", 64'(out_empty), 64'd3);
      chk("t1_fill1", 64'(fill_level), 64'd1);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("t1_fill0",  64'(fill_level), 64'd0);
      chk("t1_valid0", 64'(out_valid), 64'd0);

      // Fill to DEPTH with no reads
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 64'(i) + 64'h100, i == 0, i == DEPTH - 1, 3'(i));
         cyc();
         chk("t2_fill", 64'(fill_level), 64'(i + 1));
         chk("t2_af",   64'(almost_full), 64'((i + 1) >= 14));
      end
      chk("t2_in_ready", 64'(in_ready), 64'd0);
      chk("t2_fill16",   64'(fill_level), 64'd16);

      // Full with simultaneous write attempt and read
      drive(1'b1, 64'hDEAD, 1'b0, 1'b0, 3'd0);
      out_ready = 1'b1;
      cyc();
      drive(1'b0, 64'h0, 1'b0, 1'b0, 3'd0);
      out_ready = 1'b0;
      chk("t3_fill15",    64'(fill_level), 64'd15);
      chk("t3_in_ready1", 64'(in_ready), 64'd1);
      chk("t3_head",      out_data, 64'h101);
      drain();

      // Random traffic with incrementing payload
      cnt = 0;
      for (int c = 0; c < 60000 && cnt < 10000; c++) begin
         drive($urandom_range(0, 1) == 1, 64'(cnt) | 64'hC0DE_0000_0000_0000,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               AVST_EMPTY_W'($urandom_range(0, 7)));
         out_ready = ($urandom_range(0, 1) == 1);
         if (in_valid && m_in_ready) cnt++;
         cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_ready();
      drive(1'b1, 64'hF1F1_F1F1, 1'b0, 1'b1, 3'd0);
      cyc();
      in_valid = 1'b0;
      drain();

      // Reset with 7 entries stored
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 64'(i) + 64'h700, 1'b0, i == 6, 3'd0);
         cyc();
      end
      in_valid = 1'b0;
      chk("t5_fill7", 64'(fill_level), 64'd7);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("t5_fill0",     64'(fill_level), 64'd0);
      chk("t5_valid0",    64'(out_valid), 64'd0);
      chk("t5_ae",        64'(almost_empty), 64'd1);
      chk("t5_in_ready0", 64'(in_ready), 64'd0);
      cyc();
      chk("t5_in_ready1", 64'(in_ready), 64'd1);
      drive(1'b1, 64'h55AA_0000_1234_5678, 1'b1, 1'b1, 3'd5);
      cyc();
      in_valid = 1'b0;
      chk("t5_valid1", 64'(out_valid), 64'd1);
      chk("t5_data",   out_data, 64'h55AA_0000_1234_5678);
      chk("t5_empty",  64'(out_empty), 64'd5);
      drain();

`ifdef AVALON_SC_PKT_FIFO_SAF_EN
      // 5-beat packet with a gap before EOP
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'(i) + 64'h500, i == 0, 1'b0, 3'd0);
         cyc();
         chk("saf5_hold", 64'(out_valid), 64'd0);
      end
      in_valid = 1'b0;
      repeat (2) begin
         cyc();
         chk("saf5_gap", 64'(out_valid), 64'd0);
      end
      drive(1'b1, 64'h504, 1'b0, 1'b1, 3'd2);
      cyc();
      in_valid = 1'b0;
      chk("saf5_release", 64'(out_valid), 64'd1);
      chk("saf5_head",    out_data, 64'h500);
      drain();

      // 18-beat packet forces out_valid when full
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 64'(i) + 64'h1800, i == 0, 1'b0, 3'd0);
         cyc();
         if (i == DEPTH - 2) chk("saf18_not_full", 64'(out_valid), 64'd0);
      end
      in_valid = 1'b0;
      chk("saf18_forced",   64'(out_valid), 64'd1);
      chk("saf18_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      for (int i = DEPTH; i < DEPTH + 2; i++) begin
         wait_ready();
         drive(1'b1, 64'(i) + 64'h1800, 1'b0, i == DEPTH + 1, 3'd1);
         cyc();
         in_valid = 1'b0;
      end
      drain();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
